// File: rtl/sar_search4b.sv
// rtl/sar_search4b.sv - successive-approximation search controller driving a magnitude comparator
// Probes one bit per cycle from the MSB down, then re-checks the final code once.
module sar_search4b #(
    parameter int W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      cmp_gt,
    input  logic                      cmp_lt,
    input  logic                      cmp_eq,
    output logic [W-1:0]              guess,
    output logic                      busy,
    output logic                      done,
    output logic                      found,
    output logic                      error,
    output logic [W-1:0]              result,
    output logic [$clog2(W+2)-1:0]    steps
);

    localparam int KW = $clog2(W);
    localparam int SW = $clog2(W+2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRIAL  = 2'd1,
        S_VERIFY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [W-1:0]    r_guess;
    logic [KW-1:0]   r_k;
    logic [SW-1:0]   r_steps;
    logic            r_found;
    logic            r_error;
    logic [W-1:0]    r_result;

    logic            w_valid;
    logic            w_last;
    logic [W-1:0]    w_trial_guess;

    // Exactly one flag high: odd parity of the three, excluding all-three-high.
    assign w_valid = (cmp_gt ^ cmp_lt ^ cmp_eq) & ~(cmp_gt & cmp_lt & cmp_eq);
    assign w_last  = (r_k == '0);

    always_comb begin
        w_trial_guess = r_guess;
        if (cmp_gt) begin
            w_trial_guess[r_k] = 1'b0;
        end
        if (!w_last) begin
            w_trial_guess[r_k - 1'b1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_TRIAL;
                end
            end
            S_TRIAL: begin
                if (!w_valid || cmp_eq) begin
                    w_next = S_DONE;
                end else if (w_last) begin
                    w_next = S_VERIFY;
                end
            end
            S_VERIFY: w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_TRIAL:  busy = 1'b1;
            S_VERIFY: busy = 1'b1;
            S_DONE:   done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Search datapath; results are only touched on start acceptance and probe edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_guess  <= '0;
            r_k      <= '0;
            r_steps  <= '0;
            r_found  <= 1'b0;
            r_error  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_guess  <= {1'b1, {(W-1){1'b0}}};
                        r_k      <= KW'(W-1);
                        r_steps  <= '0;
                        r_found  <= 1'b0;
                        r_error  <= 1'b0;
                        r_result <= '0;
                    end
                end
                S_TRIAL: begin
                    r_steps <= r_steps + 1'b1;
                    if (!w_valid) begin
                        r_error <= 1'b1;
                    end else if (cmp_eq) begin
                        r_found  <= 1'b1;
                        r_result <= r_guess;
                    end else begin
                        r_guess <= w_trial_guess;
                        if (!w_last) begin
                            r_k <= r_k - 1'b1;
                        end
                    end
                end
                S_VERIFY: begin
                    r_steps <= r_steps + 1'b1;
                    if (!w_valid) begin
                        r_error <= 1'b1;
                    end else if (cmp_eq) begin
                        r_found  <= 1'b1;
                        r_result <= r_guess;
                    end
                end
                default: begin
                    r_guess <= r_guess;
                end
            endcase
        end
    end

    assign guess  = r_guess;
    assign found  = r_found;
    assign error  = r_error;
    assign result = r_result;
    assign steps  = r_steps;

endmodule
